// File: rtl/press_classifier_if.sv
// Pushbutton classifier bus: synchronized button inputs and press-event outputs.
// The master drives the button side and the slave (the classifier) drives the events.
interface press_classifier_if;
    logic       btn_rise;
    logic       btn_fall;
    logic       btn_lvl;
    logic       short_press;
    logic       long_press;
    logic       repeat_evt;
    logic       busy;
    logic [7:0] press_cnt;

    modport master (
        output btn_rise, btn_fall, btn_lvl,
        input  short_press, long_press, repeat_evt, busy, press_cnt
    );

    modport slave (
        input  btn_rise, btn_fall, btn_lvl,
        output short_press, long_press, repeat_evt, busy, press_cnt
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies pushbutton presses as short or long from synchronized rise/fall pulses.
// Optional auto-repeat while held long is enabled by defining PRESS_AUTO_REPEAT_EN.
module press_classifier #(
    parameter int CNT_W    = 16,
    parameter int LONG_CYC = 50000,
    parameter int REP_CYC  = 25000
) (
    input  logic               clk,
    input  logic               rst_n,
    press_classifier_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

    if ((LONG_CYC < 1) || (LONG_CYC > ((1 << CNT_W) - 1))) begin : g_bad_long_cyc
        $error("press_classifier: LONG_CYC out of range");
    end
    if ((REP_CYC < 1) || (REP_CYC > ((1 << CNT_W) - 1))) begin : g_bad_rep_cyc
        $error("press_classifier: REP_CYC out of range");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;

`ifdef PRESS_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYC - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dur_q     <= {CNT_W{1'b0}};
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 8'd0;
`ifdef PRESS_AUTO_REPEAT_EN
            rep_cnt_q <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            short_q   <= short_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
`ifdef PRESS_AUTO_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    // Next-state: a fall always outranks a level drop, which outranks the long transition.
    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
`ifdef PRESS_AUTO_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.btn_rise && !bus.btn_fall) begin
                    state_d = PRESSED;
                    dur_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (bus.btn_fall || !bus.btn_lvl) begin
                    state_d = IDLE;
                end else if (dur_q == LONG_LAST) begin
                    state_d = LONG_HELD;
`ifdef PRESS_AUTO_REPEAT_EN
                    rep_cnt_d = {CNT_W{1'b0}};
`endif
                end else begin
                    dur_d = dur_q + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (bus.btn_fall || !bus.btn_lvl) begin
                    state_d = IDLE;
                end else begin
                    state_d = LONG_HELD;
`ifdef PRESS_AUTO_REPEAT_EN
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; values land in the output registers one cycle after the sampling edge.
    always_comb begin
        short_d = (state_q == PRESSED)   && bus.btn_fall;
        long_d  = (state_q == LONG_HELD) && bus.btn_fall;
`ifdef PRESS_AUTO_REPEAT_EN
        rep_d   = (state_q == LONG_HELD) && !bus.btn_fall && bus.btn_lvl
                  && (rep_cnt_q == REP_LAST);
`else
        rep_d   = 1'b0;
`endif
        busy_d  = (state_d != IDLE);
        if (short_d || long_d) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;
    assign bus.repeat_evt  = rep_q;
    assign bus.busy        = busy_q;
    assign bus.press_cnt   = cnt_q;

endmodule
